fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly downstream of the program counter. It issues byte reads at the PC address, handles memory wait states, and pulses the PC increment once per byte consumed. It assembles 1- or 2-byte instructions and hands them to the decoder over a valid/ready handshake. A flush from execute discards any partial or held instruction when the PC is reloaded.

## Interface
Parameters:
- ADDR_W, 16, address width (matches PC output)
- DATA_W, 8, memory data / opcode / operand width
- TIMEOUT_CYCLES, 15, maximum wait-state cycles per read (used only with FETCH_TIMEOUT_EN)

Ports:
- clock  in  1  clock; all state changes on posedge
- reset  in  1  reset, synchronous, active-high
- pc_addr  in  ADDR_W  current PC value
- pc_inc  out  1  one-cycle increment request to PC
- flush  in  1  branch/jump taken; PC loads on the same edge
- mem_addr  out  ADDR_W  read address, equals pc_addr
- mem_rd  out  1  read request
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- mem_ready  in  1  read completes this cycle
- instr_valid  out  1  instruction available
- instr_ready  in  1  decoder accepts instruction
- instr_opcode  out  DATA_W  opcode byte
- instr_operand  out  DATA_W  operand byte (0 for 1-byte instructions)
- instr_len2  out  1  1 = 2-byte instruction
- fetch_err  out  1  sticky read timeout (FETCH_TIMEOUT_EN only, else tied 0)

## Operation
- States: FETCH_OP, FETCH_ARG, HOLD, ERROR (ERROR only with FETCH_TIMEOUT_EN).
- Length rule: opcode[7]=1 means 2-byte instruction.
- FETCH_OP: mem_rd=1. On mem_ready, latch opcode and assert pc_inc. If opcode[7]=1, go to FETCH_ARG. Otherwise set operand=0, len2=0, and go to HOLD.
- FETCH_ARG: mem_rd=1. On mem_ready, latch operand, set len2=1, assert pc_inc, and go to HOLD.
- HOLD: instr_valid=1 with opcode/operand/len2 stable. mem_rd=0. When instr_valid&instr_ready, go to FETCH_OP.
- mem_rd and pc_inc are combinational from state and inputs.
  - pc_inc = mem_rd & mem_ready.
  - mem_addr = pc_addr, always.
- flush (priority below reset):
  - mem_rd=0 and pc_inc=0 in the flush cycle, even if mem_ready=1.
  - instr_valid drops at the next edge.
  - State goes to FETCH_OP.
  - Any latched opcode is discarded.
- flush while in HOLD with instr_ready=1: the flush wins. The instruction is considered not accepted; the decoder must also ignore it.
- reset: state goes to FETCH_OP. instr_valid, instr_opcode, instr_operand, instr_len2 and fetch_err are all 0. mem_rd and pc_inc are forced 0 while reset is high.
- Reset or flush during a wait state abandons the read. Memory must tolerate an abandoned request.

## Timing
- Zero-wait memory, 1-byte instruction: read cycle N, instr_valid at N+1. With instr_ready=1 at N+1, the next read is issued at N+2. Throughput is 1 byte instruction per 2 cycles.
- 2-byte instruction, zero-wait: reads at N and N+1, instr_valid at N+2.
- Each wait state adds one cycle. mem_addr and mem_rd are held stable until mem_ready.
- pc_addr reflects the increment on the cycle after pc_inc, so FETCH_ARG reads the next address.
- After flush at cycle N, the first read of the target is at N+1.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A wait counter clears on each new read and counts cycles with mem_rd=1 and mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES, fetch_err is set (sticky), the state goes to ERROR, and mem_rd=0.
  - ERROR exits only on reset or flush. flush clears fetch_err.
- FETCH_TIMEOUT_EN undefined: no counter and no ERROR state. fetch_err is tied 0 and the unit waits indefinitely.

## Structure
- Shared package (cpu_pkg): ADDR_W/DATA_W constants, fetch state enum, OPC_LEN2_BIT=7.
- No sub-module needed. The timeout counter stays inline, guarded by the macro.

## Test plan
- Reset, pc_addr=0x0010, memory returns 0x12 with zero wait:
  - mem_rd at cycle 1 after reset.
  - pc_inc pulses once.
  - Next cycle: instr_valid=1, opcode=0x12, operand=0x00, len2=0.
- 2-byte: memory holds 0x85,0x3C at 0x0020/0x0021:
  - Two reads, two pc_inc pulses.
  - Then instr_valid with opcode=0x85, operand=0x3C, len2=1.
- Backpressure: instr_ready=0 for 5 cycles in HOLD:
  - Outputs stable, mem_rd=0, no pc_inc.
  - Accepted on the first ready cycle, then FETCH_OP.
- Wait states: mem_ready delayed 3 cycles:
  - mem_addr and mem_rd held stable.
  - Exactly one pc_inc, on the ready cycle.
- Flush during FETCH_ARG with mem_ready=1 in the same cycle:
  - No pc_inc, no instr_valid.
  - Next cycle reads the new pc_addr=0x0100.
- FETCH_TIMEOUT_EN with mem_ready stuck at 0:
  - fetch_err=1 after 15 wait cycles, then mem_rd=0.
  - flush clears fetch_err and restarts the fetch.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, fetch states, opcode length rule.
// ERROR state exists only when FETCH_TIMEOUT_EN is defined.
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int OPC_LEN2_BIT = 7;

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_ARG,
    HOLD
`ifdef FETCH_TIMEOUT_EN
    ,
    ERROR
`endif
  } fetch_state_t;

  function automatic logic is_len2(
    input logic [DATA_W-1:0] opc
  );
    return opc[OPC_LEN2_BIT];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: byte reads at PC, 1/2-byte assembly, decoder handshake.
// Optional read timeout with sticky fetch_err: define FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_inc,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic              instr_len2,
  output logic              fetch_err
);
  import cpu_pkg::*;

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [DATA_W-1:0] opc_q;
  logic [DATA_W-1:0] opc_d;
  logic [DATA_W-1:0] arg_q;
  logic [DATA_W-1:0] arg_d;
  logic              len2_q;
  logic              len2_d;

  logic reading;
  logic op_done;
  logic arg_done;
  logic accept;
  logic expire;

  assign mem_addr = pc_addr;

  assign reading = (state_q == FETCH_OP)
                 | (state_q == FETCH_ARG);

  // flush and reset abandon any read in flight
  assign mem_rd = reading & ~reset & ~flush;
  assign pc_inc = mem_rd & mem_ready;

  assign op_done  = pc_inc & (state_q == FETCH_OP);
  assign arg_done = pc_inc & (state_q == FETCH_ARG);

  assign instr_valid   = (state_q == HOLD);
  assign instr_opcode  = opc_q;
  assign instr_operand = arg_q;
  assign instr_len2    = len2_q;

  // a flush in the same cycle as ready means not accepted
  assign accept = instr_valid & instr_ready & ~flush;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_q;
  logic          stall;
  logic          err_q;

  assign stall  = mem_rd & ~mem_ready;
  assign expire = stall
                & (wait_q == CW'(TIMEOUT_CYCLES - 1));

  // wait-state counter, cleared whenever no read is stalled
  always_ff @(posedge clock) begin
    if (reset | ~stall) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_q + 1'b1;
    end
  end

  // sticky timeout flag, cleared only by reset or flush
  always_ff @(posedge clock) begin
    if (reset | flush) begin
      err_q <= 1'b0;
    end else if (expire) begin
      err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign expire    = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // next state and instruction latches
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    arg_d   = arg_q;
    len2_d  = len2_q;
    unique case (1'b1)
      flush: begin
        state_d = FETCH_OP;
        opc_d   = '0;
        arg_d   = '0;
        len2_d  = 1'b0;
      end
`ifdef FETCH_TIMEOUT_EN
      expire: begin
        state_d = ERROR;
      end
`endif
      op_done: begin
        opc_d = mem_rdata;
        if (is_len2(mem_rdata)) begin
          state_d = FETCH_ARG;
        end else begin
          arg_d   = '0;
          len2_d  = 1'b0;
          state_d = HOLD;
        end
      end
      arg_done: begin
        arg_d   = mem_rdata;
        len2_d  = 1'b1;
        state_d = HOLD;
      end
      accept: begin
        state_d = FETCH_OP;
      end
      default: begin
      end
    endcase
  end

  // state and instruction registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH_OP;
      opc_q   <= '0;
      arg_q   <= '0;
      len2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      arg_q   <= arg_d;
      len2_q  <= len2_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based instruction model, directed + random.
// Timeout checks are active when FETCH_TIMEOUT_EN is defined.
module tb_fetch_unit;

  localparam int TO = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] pc_addr = 16'h0;
  logic        pc_inc;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_operand;
  logic        instr_len2;
  logic        fetch_err;

  logic [7:0] mem [0:65535];

  assign mem_rdata = mem[mem_addr];

  always #5 clock = ~clock;

  fetch_unit #(
    .ADDR_W(16),
    .DATA_W(8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pc_addr(pc_addr),
    .pc_inc(pc_inc),
    .flush(flush),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_opcode(instr_opcode),
    .instr_operand(instr_operand),
    .instr_len2(instr_len2),
    .fetch_err(fetch_err)
  );

  int errors = 0;
  int checks = 0;
  int inc_cnt = 0;
  bit armed = 1'b0;

  // model: bytes collected for the instruction in progress
  logic [7:0] q[$];
  bit m_err = 1'b0;
  int m_wc = 0;

  function automatic bit m_valid();
    if (q.size() == 2) return 1'b1;
    if (q.size() == 1) return !q[0][7];
    return 1'b0;
  endfunction

  function automatic bit m_rd();
    return !reset && !flush && !m_valid() && !m_err;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clock) begin
    if (armed) begin
      chk("mem_addr", 32'(mem_addr), 32'(pc_addr));
      chk("mem_rd", 32'(mem_rd), 32'(m_rd()));
      chk("pc_inc", 32'(pc_inc), 32'(m_rd() & mem_ready));
      chk("valid", 32'(instr_valid), 32'(m_valid()));
      if (m_valid()) begin
        chk("opcode", 32'(instr_opcode), 32'(q[0]));
        chk("operand", 32'(instr_operand),
            (q.size() == 2) ? 32'(q[1]) : 32'h0);
        chk("len2", 32'(instr_len2), 32'(q.size() == 2));
      end
      chk("fetch_err", 32'(fetch_err), 32'(m_err));
      inc_cnt += int'(pc_inc);
    end
  end

  // one clock: drive inputs, sample mid-cycle, advance model and PC
  task automatic step(
    input bit          rst,
    input bit          fl,
    input logic [15:0] tgt,
    input bit          rdy,
    input bit          ack
  );
    bit rd;
    bit v;
    bit inc;
    logic [7:0] b;
    reset       = rst;
    flush       = fl;
    mem_ready   = rdy;
    instr_ready = ack;
    @(negedge clock);
    rd  = m_rd();
    v   = m_valid();
    inc = pc_inc;
    b   = mem[pc_addr];
    @(posedge clock);
    #1;
    if (rst) begin
      q.delete();
      m_err = 1'b0;
      m_wc  = 0;
    end else if (fl) begin
      q.delete();
      m_err = 1'b0;
      m_wc  = 0;
    end else if (v && ack) begin
      q.delete();
    end else if (rd && rdy) begin
      q.push_back(b);
      m_wc = 0;
    end else if (rd) begin
      m_wc++;
`ifdef FETCH_TIMEOUT_EN
      if (m_wc == TO) m_err = 1'b1;
`endif
    end
    if (!rst && fl) pc_addr = tgt;
    else if (!rst && inc) pc_addr = pc_addr + 16'd1;
  endtask

  int i0;

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 8'($urandom);
    end
    mem[16'h0010] = 8'h12;
    mem[16'h0020] = 8'h85;
    mem[16'h0021] = 8'h3C;
    mem[16'h0022] = 8'h05;
    mem[16'h0023] = 8'h9A;
    mem[16'h0100] = 8'h33;

    pc_addr = 16'h0010;
    step(1, 0, 16'h0, 0, 0);
    armed = 1'b1;
    step(1, 0, 16'h0, 0, 0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_opcode", 32'(instr_opcode), 32'h0);
    chk("rst_operand", 32'(instr_operand), 32'h0);
    chk("rst_len2", 32'(instr_len2), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);

    // 1-byte, zero wait
    i0 = inc_cnt;
    step(0, 0, 16'h0, 1, 0);
    chk("b1_valid", 32'(instr_valid), 32'h1);
    chk("b1_opcode", 32'(instr_opcode), 32'h12);
    chk("b1_operand", 32'(instr_operand), 32'h00);
    chk("b1_len2", 32'(instr_len2), 32'h0);
    chk("b1_incs", 32'(inc_cnt - i0), 32'd1);
    chk("b1_pc", 32'(pc_addr), 32'h0011);

    // backpressure in HOLD
    i0 = inc_cnt;
    repeat (5) step(0, 0, 16'h0, 1, 0);
    chk("bp_incs", 32'(inc_cnt - i0), 32'd0);
    chk("bp_opcode", 32'(instr_opcode), 32'h12);
    chk("bp_valid", 32'(instr_valid), 32'h1);
    step(0, 0, 16'h0, 1, 1);
    chk("bp_accept", 32'(instr_valid), 32'h0);

    // 2-byte after a flush to 0x0020
    step(0, 1, 16'h0020, 0, 0);
    i0 = inc_cnt;
    step(0, 0, 16'h0, 1, 0);
    chk("b2_midvalid", 32'(instr_valid), 32'h0);
    step(0, 0, 16'h0, 1, 0);
    chk("b2_valid", 32'(instr_valid), 32'h1);
    chk("b2_opcode", 32'(instr_opcode), 32'h85);
    chk("b2_operand", 32'(instr_operand), 32'h3C);
    chk("b2_len2", 32'(instr_len2), 32'h1);
    chk("b2_incs", 32'(inc_cnt - i0), 32'd2);
    chk("b2_pc", 32'(pc_addr), 32'h0022);
    step(0, 0, 16'h0, 0, 1);

    // three wait states
    i0 = inc_cnt;
    repeat (3) step(0, 0, 16'h0, 0, 0);
    chk("ws_incs0", 32'(inc_cnt - i0), 32'd0);
    chk("ws_pc", 32'(pc_addr), 32'h0022);
    step(0, 0, 16'h0, 1, 0);
    chk("ws_incs1", 32'(inc_cnt - i0), 32'd1);
    chk("ws_opcode", 32'(instr_opcode), 32'h05);
    step(0, 0, 16'h0, 0, 1);

    // flush in FETCH_ARG with mem_ready high
    step(0, 0, 16'h0, 1, 0);
    i0 = inc_cnt;
    step(0, 1, 16'h0100, 1, 0);
    chk("fl_incs", 32'(inc_cnt - i0), 32'd0);
    chk("fl_valid", 32'(instr_valid), 32'h0);
    step(0, 0, 16'h0, 1, 0);
    chk("fl_pc", 32'(pc_addr), 32'h0101);
    chk("fl_opcode", 32'(instr_opcode), 32'h33);
    step(0, 0, 16'h0, 0, 1);

`ifdef FETCH_TIMEOUT_EN
    step(0, 1, 16'h0200, 0, 0);
    repeat (TO - 1) step(0, 0, 16'h0, 0, 0);
    chk("to_early", 32'(fetch_err), 32'h0);
    step(0, 0, 16'h0, 0, 0);
    chk("to_err", 32'(fetch_err), 32'h1);
    chk("to_rd", 32'(mem_rd), 32'h0);
    repeat (3) step(0, 0, 16'h0, 1, 0);
    chk("to_sticky", 32'(fetch_err), 32'h1);
    step(0, 1, 16'h0300, 0, 0);
    chk("to_clear", 32'(fetch_err), 32'h0);
    chk("to_restart", 32'(mem_rd), 32'h1);
`endif

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(99) == 0,
           $urandom_range(19) == 0,
           16'($urandom),
           $urandom_range(9) < 6,
           $urandom_range(9) < 6);
    end

    armed = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
